// File: rtl/uart_fb_pkg.sv
// uart_fb_pkg: shared state type, default constants and slot base-address helper
package uart_fb_pkg;
  typedef enum logic [1:0] {IDLE, SLOT, DATA, CSUM} state_t;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int DEF_FRAME_PIXELS = 307200;
  localparam int DEF_ADDR_W = 23;
  function automatic longint unsigned slot_base(input longint unsigned slot, input longint unsigned frame_pixels);
    return slot * frame_pixels;
  endfunction
endpackage

// File: rtl/uart_frame_writer_packer.sv
// uart_byte_packer: packs BYTES_PER_PIX bytes big-endian into a zero-extended pixel with a valid strobe
module uart_byte_packer #(
  parameter int BYTES_PER_PIX = 1,
  parameter int PIX_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [7:0]       i_byte,
  input  logic             i_valid,
  output logic             o_last,
  output logic [PIX_W-1:0] o_pix,
  output logic             o_pix_valid
);
  localparam int CW = BYTES_PER_PIX > 1 ? $clog2(BYTES_PER_PIX) : 1;
  localparam int BW = 8 * BYTES_PER_PIX;
  logic [BW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] w_word;
  assign w_word = (r_acc << 8) | BW'(i_byte);
  assign o_last = i_valid && r_cnt == CW'(BYTES_PER_PIX - 1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      o_pix <= '0;
      o_pix_valid <= 1'b0;
    end else begin
      o_pix_valid <= o_last;
      if (o_last) o_pix <= PIX_W'(w_word);
      if (i_clr || o_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_valid) begin
        r_acc <= w_word;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_frame_writer.sv
// uart_frame_writer: turns framed UART bytes (sync, slot, payload) into SDRAM frame-buffer pixel writes.
// Define UART_FRAME_CHECKSUM_EN to add a trailing mod-256 payload checksum byte and the oERR_CSUM flag.
module uart_frame_writer
  import uart_fb_pkg::*;
#(
  parameter int BYTES_PER_PIX = 1,
  parameter int PIX_W = 16,
  parameter int NUM_SLOTS = 5,
  parameter int SLOT_W = 3,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [7:0]        iBYTE,
  input  logic              iBYTE_VALID,
  output logic [PIX_W-1:0]  oWR_DATA,
  output logic              oWR,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic              oFRAME_START,
  output logic              oFRAME_DONE,
  output logic [SLOT_W-1:0] oSLOT,
  output logic              oBUSY,
  output logic              oERR_TIMEOUT,
  output logic              oERR_SLOT
`ifdef UART_FRAME_CHECKSUM_EN
  , output logic            oERR_CSUM
`endif
);
  localparam int PW = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam longint unsigned LAST_ADDR = slot_base(64'(NUM_SLOTS - 1), 64'(FRAME_PIXELS)) + 64'(FRAME_PIXELS) - 64'd1;
  if (BYTES_PER_PIX < 1 || BYTES_PER_PIX > 2 || PIX_W < 8 * BYTES_PER_PIX) begin : g_bad_fmt
    $error("uart_frame_writer: illegal BYTES_PER_PIX/PIX_W combination");
  end
  if (LAST_ADDR >= (64'd1 << ADDR_W)) begin : g_bad_addr
    $error("uart_frame_writer: last slot address does not fit in ADDR_W");
  end
  if ((64'd1 << SLOT_W) < 64'(NUM_SLOTS)) begin : g_bad_slot
    $error("uart_frame_writer: SLOT_W too narrow for NUM_SLOTS");
  end
  state_t r_state, w_state_next, w_end_state;
  logic [SLOT_W-1:0] r_slot;
  logic [ADDR_W-1:0] r_base, r_addr;
  logic [PW-1:0] r_pix;
  logic [TW-1:0] r_tmo;
  logic r_start, r_done, r_err_tmo, r_err_slot;
  logic w_sync, w_slot_ok, w_slot_acc, w_slot_bad, w_tmo, w_last, w_frame_end, w_done_next;
  assign w_sync = r_state == IDLE && iBYTE_VALID && iBYTE == SYNC_BYTE;
  assign w_slot_ok = {1'b0, iBYTE} < 9'(NUM_SLOTS);
  assign w_slot_acc = r_state == SLOT && iBYTE_VALID && w_slot_ok;
  assign w_slot_bad = r_state == SLOT && iBYTE_VALID && !w_slot_ok;
  // a byte arriving on the expiry cycle keeps the frame alive
  assign w_tmo = r_state != IDLE && !iBYTE_VALID && r_tmo == TW'(TIMEOUT_CYC - 1);
  assign w_frame_end = w_last && r_pix == PW'(FRAME_PIXELS - 1);
  uart_byte_packer #(
    .BYTES_PER_PIX(BYTES_PER_PIX),
    .PIX_W(PIX_W)
  ) u_packer (
    .i_clk(iCLK),
    .i_rst(iRST),
    .i_clr(r_state != DATA),
    .i_byte(iBYTE),
    .i_valid(iBYTE_VALID && r_state == DATA),
    .o_last(w_last),
    .o_pix(oWR_DATA),
    .o_pix_valid(oWR)
  );
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] r_sum;
  logic r_err_csum;
  logic w_csum_acc;
  assign w_csum_acc = r_state == CSUM && iBYTE_VALID;
  assign w_end_state = CSUM;
  assign w_done_next = w_csum_acc;
  assign oERR_CSUM = r_err_csum;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_sum <= '0;
      r_err_csum <= 1'b0;
    end else begin
      r_sum <= w_slot_acc ? 8'd0 : (r_state == DATA && iBYTE_VALID) ? r_sum + iBYTE : r_sum;
      r_err_csum <= w_sync ? 1'b0 : (w_csum_acc && iBYTE != r_sum) ? 1'b1 : r_err_csum;
    end
  end
`else
  assign w_end_state = IDLE;
  assign w_done_next = w_frame_end;
`endif
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: w_state_next = w_sync ? SLOT : IDLE;
      SLOT: w_state_next = w_slot_acc ? DATA : (w_slot_bad || w_tmo) ? IDLE : SLOT;
      DATA: w_state_next = w_frame_end ? w_end_state : w_tmo ? IDLE : DATA;
      default: w_state_next = (iBYTE_VALID || w_tmo) ? IDLE : CSUM;
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_slot <= '0;
      r_base <= '0;
      r_addr <= '0;
      r_pix <= '0;
      r_tmo <= '0;
      r_start <= 1'b0;
      r_done <= 1'b0;
      r_err_tmo <= 1'b0;
      r_err_slot <= 1'b0;
    end else begin
      r_start <= w_slot_acc;
      r_done <= w_done_next;
      r_tmo <= (r_state == IDLE || iBYTE_VALID || w_tmo) ? '0 : r_tmo + 1'b1;
      r_err_tmo <= w_sync ? 1'b0 : w_tmo ? 1'b1 : r_err_tmo;
      r_err_slot <= w_sync ? 1'b0 : w_slot_bad ? 1'b1 : r_err_slot;
      if (w_slot_acc) begin
        r_slot <= iBYTE[SLOT_W-1:0];
        r_base <= ADDR_W'(slot_base(64'(iBYTE[SLOT_W-1:0]), 64'(FRAME_PIXELS)));
        r_pix <= '0;
      end else if (w_last) begin
        r_addr <= r_base + ADDR_W'(r_pix);
        r_pix <= w_frame_end ? '0 : r_pix + 1'b1;
      end
    end
  end
  assign oWR_ADDR = r_addr;
  assign oFRAME_START = r_start;
  assign oFRAME_DONE = r_done;
  assign oSLOT = r_slot;
  assign oBUSY = r_state != IDLE;
  assign oERR_TIMEOUT = r_err_tmo;
  assign oERR_SLOT = r_err_slot;
endmodule

// File: doc/uart_frame_writer.md
Name: uart_frame_writer

Overview:
- Turns the UART receiver's byte stream into pixel write requests for the SDRAM frame-buffer write port.
- Supports NUM_SLOTS selectable frame slots. It generalises the current fixed path (one byte becomes one 16-bit word at a fixed base) to configurable bytes-per-pixel, pixel width, slot count and frame size.
- Adds framed transfers: a sync byte and a slot byte, then the pixel payload, with an inter-byte timeout.
- Sits between uart_rx (po_data/po_flag) and Sdram_Control WR1.

Parameters:
- BYTES_PER_PIX, 1: UART bytes per pixel, legal 1..2.
- PIX_W, 16: output pixel width. Must satisfy PIX_W >= 8*BYTES_PER_PIX.
- NUM_SLOTS, 5: number of frame slots.
- SLOT_W, 3: slot index width, >= clog2(NUM_SLOTS).
- FRAME_PIXELS, 307200: pixels per frame (640*480).
- ADDR_W, 23: SDRAM word address width.
- SYNC_BYTE, 8'hA5: frame header byte.
- TIMEOUT_CYC, 5000000: maximum idle cycles between bytes inside a frame (100 ms at 50 MHz).

Ports:
- iCLK  in  1  system clock (CLOCK_50 domain)
- iRST  in  1  synchronous reset, active-high
- iBYTE  in  8  received UART byte
- iBYTE_VALID  in  1  single-cycle strobe, iBYTE valid
- oWR_DATA  out  PIX_W  packed pixel
- oWR  out  1  single-cycle write strobe
- oWR_ADDR  out  ADDR_W  word address of oWR_DATA
- oFRAME_START  out  1  pulse when payload begins (slot accepted)
- oFRAME_DONE  out  1  pulse after last pixel written
- oSLOT  out  SLOT_W  slot of the current/last frame
- oBUSY  out  1  high in SLOT or DATA state
- oERR_TIMEOUT  out  1  sticky, frame aborted by timeout
- oERR_SLOT  out  1  sticky, slot byte >= NUM_SLOTS

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Sticky errors clear only on iRST, or on the next accepted SYNC_BYTE in IDLE.
- Bytes are considered only when iBYTE_VALID=1. No backpressure: the downstream FIFO must absorb one word per BYTES_PER_PIX bytes.
- State IDLE:
  - byte == SYNC_BYTE -> SLOT.
  - Any other byte is discarded.
- State SLOT:
  - byte < NUM_SLOTS: latch oSLOT = byte[SLOT_W-1:0], base = slot*FRAME_PIXELS, pixel counter = 0, byte-in-pixel counter = 0. Pulse oFRAME_START the next cycle, then go to DATA.
  - byte >= NUM_SLOTS: set oERR_SLOT and return to IDLE.
- State DATA:
  - Bytes are packed big-endian: the first byte of a pixel lands in the most-significant used byte. The pixel is zero-extended to PIX_W.
  - On the last byte of a pixel, the cycle after acceptance: oWR=1 for one cycle, oWR_DATA = packed value, oWR_ADDR = base + pixel index. Latency from final byte strobe to oWR is exactly 1 cycle.
  - SYNC_BYTE values inside DATA are ordinary data.
  - After pixel FRAME_PIXELS-1 is written: pulse oFRAME_DONE in the same cycle as that final oWR, then go to IDLE (or CSUM when the option is compiled in).
- Timeout:
  - The counter resets on every accepted byte while in SLOT/DATA/CSUM.
  - On reaching TIMEOUT_CYC-1 with no byte: set oERR_TIMEOUT, return to IDLE, discard any partial pixel, no oFRAME_DONE.
  - A byte arriving in the same cycle as expiry wins: it is accepted and the counter restarts.
- Address arithmetic: base is computed as a constant multiply, truncated to ADDR_W. The slot*FRAME_PIXELS + FRAME_PIXELS-1 must fit in ADDR_W; this is checked by an elaboration-time assertion.
- Reset mid-frame: immediate abort. Already-issued writes stand; no further strobes.
- oBUSY is high in SLOT, DATA and CSUM; low in IDLE.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Compiled in:
  - An 8-bit running sum of all DATA-state bytes (mod 256) is kept.
  - After the last pixel, state CSUM waits for one byte. Mismatch sets sticky output oERR_CSUM (extra port, 1 bit). Either way the block returns to IDLE.
  - oFRAME_DONE moves to the cycle after the checksum byte is accepted.
  - Timeout applies in CSUM.
- Compiled out: no CSUM state, no oERR_CSUM port, oFRAME_DONE as described above.

Decomposition:
- Shared package uart_fb_pkg: state enum (IDLE, SLOT, DATA, CSUM), default SYNC_BYTE, FRAME_PIXELS, and ADDR_W constants, and a function computing slot base address.
- One natural sub-module, uart_byte_packer: accumulates BYTES_PER_PIX bytes and emits a packed pixel with a valid strobe. It is cleared on frame start or abort.

Test Plan:
- BYTES_PER_PIX=1, FRAME_PIXELS=4. Send A5,02,11,22,33,44 -> oFRAME_START once. oWR at addresses 8,9,10,11 with data 0011,0022,0033,0044. oFRAME_DONE coincides with the 4th oWR.
- BYTES_PER_PIX=2. Send A5,00,12,34,56,78 -> oWR_DATA 1234 at addr 0, then 5678 at addr 1. Each oWR occurs 1 cycle after the second byte of its pixel.
- Send A5,07 with NUM_SLOTS=5 -> oERR_SLOT=1, no oWR, state IDLE. Then send 5A,A5,00 -> no start on 5A; start on A5,00; oERR_SLOT cleared on that A5.
- TIMEOUT_CYC=100. Send A5,01,one byte (BYTES_PER_PIX=2), then idle 100 cycles -> oERR_TIMEOUT=1, no oWR, oBUSY=0. Next frame starts cleanly with byte counter 0.
- Assert iRST after 2 of 4 pixels -> all outputs 0 on the next cycle, no oFRAME_DONE. A fresh frame then writes from pixel index 0.
- UART_FRAME_CHECKSUM_EN, FRAME_PIXELS=2. Send A5,00,10,20,30 -> oFRAME_DONE, oERR_CSUM=0. Repeat with trailer 31 -> oERR_CSUM=1.
